// File: rtl/storage_mgmt_arbiter_if.sv
// Requester-side native access channel into the storage management arbiter.
// The requester drives the command fields; the arbiter returns grant and read response.
interface storage_mgmt_arbiter_if #(
  parameter int BLK_W = 1
);
  logic             req;
  logic             gnt;
  logic             we;
  logic [BLK_W-1:0] blk;
  logic [7:0]       addr;
  logic [3:0]       wmask;
  logic [31:0]      wdata;
  logic             rvalid;
  logic [31:0]      rdata;

  modport master (
    output req, we, blk, addr, wmask, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, blk, addr, wmask, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/storage_mgmt_arbiter.sv
// Two-requester sticky round-robin arbiter with burst cap in front of the
// storage area's single management R/W SRAM port; read data returns one cycle later.
module storage_mgmt_arbiter #(
  parameter int RAM_BLOCKS = 2,
  parameter int BLK_W      = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  storage_mgmt_arbiter_if.slave   r0,
  storage_mgmt_arbiter_if.slave   r1,
  output logic [RAM_BLOCKS-1:0]   mgmt_ena,
  output logic [RAM_BLOCKS-1:0]   mgmt_wen,
  output logic [RAM_BLOCKS*4-1:0] mgmt_wen_mask,
  output logic [7:0]              mgmt_addr,
  output logic [31:0]             mgmt_wdata,
  input  logic [RAM_BLOCKS*32-1:0] mgmt_rdata
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic             last_q, last_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic             rsp_id_q, rsp_id_d;
  logic [BLK_W-1:0] rsp_blk_q, rsp_blk_d;

  logic             req0, req1, accept, win;
  logic             sel_we;
  logic [BLK_W-1:0] sel_blk;
  logic [3:0]       sel_wmask;
  logic [7:0]       sel_addr;
  logic [31:0]      sel_wdata;
  logic             rvalid_any;
  logic [31:0]      rdata_sel;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req0   = r0.req & ~wb_rst_i;
    req1   = r1.req & ~wb_rst_i;
    accept = req0 | req1;

    // A zero burst count means no burst is in progress, so contention rotates
    // away from last; otherwise stay sticky until the cap is reached.
    if (req0 && req1) begin
      if (burst_cnt_q == 4'd0 || burst_cnt_q >= MAX_B) win = ~last_q;
      else                                             win = last_q;
    end else begin
      win = req1;
    end

    sel_we    = win ? r1.we    : r0.we;
    sel_blk   = win ? r1.blk   : r0.blk;
    sel_wmask = win ? r1.wmask : r0.wmask;
    sel_addr  = win ? r1.addr  : r0.addr;
    sel_wdata = win ? r1.wdata : r0.wdata;

    r0.gnt = accept & ~win;
    r1.gnt = accept &  win;

    mgmt_ena      = '0;
    mgmt_wen      = '0;
    mgmt_wen_mask = '0;
    mgmt_addr     = '0;
    mgmt_wdata    = '0;
    if (accept) begin
      mgmt_addr  = sel_addr;
      mgmt_wdata = sel_wdata;
      // Out-of-range block indices match no bit and leave the macro idle.
      for (int b = 0; b < RAM_BLOCKS; b++) begin
        if (int'(sel_blk) == b) begin
          mgmt_ena[b]          = 1'b1;
          mgmt_wen[b]          = sel_we;
          mgmt_wen_mask[b*4 +: 4] = sel_we ? sel_wmask : 4'h0;
        end
      end
    end

    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (accept) begin
      if (win == last_q) begin
        if (burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 4'd1;
      end else begin
        last_d      = win;
        burst_cnt_d = 4'd1;
      end
    end else begin
      burst_cnt_d = 4'd0;
    end

    rsp_pend_d = accept & ~sel_we;
    rsp_id_d   = rsp_id_q;
    rsp_blk_d  = rsp_blk_q;
    if (accept && !sel_we) begin
      rsp_id_d  = win;
      rsp_blk_d = sel_blk;
    end

    rdata_sel = 32'h0;
    for (int b = 0; b < RAM_BLOCKS; b++) begin
      if (int'(rsp_blk_q) == b) rdata_sel = mgmt_rdata[b*32 +: 32];
    end

    rvalid_any = rsp_pend_q & ~wb_rst_i;
    r0.rvalid  = rvalid_any & ~rsp_id_q;
    r1.rvalid  = rvalid_any &  rsp_id_q;
    r0.rdata   = (rvalid_any && !rsp_id_q) ? rdata_sel : 32'h0;
    r1.rdata   = (rvalid_any &&  rsp_id_q) ? rdata_sel : 32'h0;
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_q      <= 1'b1;
      burst_cnt_q <= 4'd0;
      rsp_pend_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_blk_q   <= '0;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_id_q    <= rsp_id_d;
      rsp_blk_q   <= rsp_blk_d;
    end
  end

endmodule

// File: tb/tb_storage_mgmt_arbiter.sv
// Directed bench for storage_mgmt_arbiter: a two-block SRAM model behind the main
// instance, plus a single-block instance for out-of-range block accesses.
module tb_storage_mgmt_arbiter;

  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  storage_mgmt_arbiter_if #(.BLK_W(1)) r0 ();
  storage_mgmt_arbiter_if #(.BLK_W(1)) r1 ();
  storage_mgmt_arbiter_if #(.BLK_W(1)) s0 ();
  storage_mgmt_arbiter_if #(.BLK_W(1)) s1 ();

  logic [1:0]  mgmt_ena, mgmt_wen;
  logic [7:0]  mgmt_wen_mask, mgmt_addr;
  logic [31:0] mgmt_wdata;
  logic [63:0] mgmt_rdata;

  logic [0:0]  oor_ena, oor_wen;
  logic [3:0]  oor_wen_mask;
  logic [7:0]  oor_addr;
  logic [31:0] oor_wdata;
  logic [31:0] oor_rdata;
  assign oor_rdata = 32'hCAFE_F00D;

  storage_mgmt_arbiter #(.RAM_BLOCKS(2), .BLK_W(1), .MAX_BURST(4)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .r0(r0.slave), .r1(r1.slave),
    .mgmt_ena(mgmt_ena), .mgmt_wen(mgmt_wen), .mgmt_wen_mask(mgmt_wen_mask),
    .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata), .mgmt_rdata(mgmt_rdata)
  );

  storage_mgmt_arbiter #(.RAM_BLOCKS(1), .BLK_W(1), .MAX_BURST(4)) u_dut_oor (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .r0(s0.slave), .r1(s1.slave),
    .mgmt_ena(oor_ena), .mgmt_wen(oor_wen), .mgmt_wen_mask(oor_wen_mask),
    .mgmt_addr(oor_addr), .mgmt_wdata(oor_wdata), .mgmt_rdata(oor_rdata)
  );

  // SRAM model: registered read data, byte-masked writes.
  logic [31:0] mem [2][256];
  logic [31:0] rd  [2];
  assign mgmt_rdata = {rd[1], rd[0]};
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mgmt_ena[b]) begin
        if (mgmt_wen[b]) begin
          for (int i = 0; i < 4; i++)
            if (mgmt_wen_mask[b*4+i]) mem[b][mgmt_addr][8*i +: 8] <= mgmt_wdata[8*i +: 8];
        end else begin
          rd[b] <= mem[b][mgmt_addr];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    r0.req = 0; r0.we = 0; r0.blk = 0; r0.addr = 0; r0.wmask = 0; r0.wdata = 0;
    r1.req = 0; r1.we = 0; r1.blk = 0; r1.addr = 0; r1.wmask = 0; r1.wdata = 0;
    s0.req = 0; s0.we = 0; s0.blk = 0; s0.addr = 0; s0.wmask = 0; s0.wdata = 0;
    s1.req = 0; s1.we = 0; s1.blk = 0; s1.addr = 0; s1.wmask = 0; s1.wdata = 0;
  endtask

  task automatic set0(input logic we, input logic [0:0] blk, input logic [7:0] addr,
                      input logic [3:0] mask, input logic [31:0] data);
    r0.req = 1; r0.we = we; r0.blk = blk; r0.addr = addr; r0.wmask = mask; r0.wdata = data;
  endtask

  task automatic set1(input logic we, input logic [0:0] blk, input logic [7:0] addr,
                      input logic [3:0] mask, input logic [31:0] data);
    r1.req = 1; r1.we = we; r1.blk = blk; r1.addr = addr; r1.wmask = mask; r1.wdata = data;
  endtask

  task automatic reset_pulse();
    cyc(); idle_all(); wb_rst_i = 1;
    cyc(); wb_rst_i = 0;
  endtask

  task automatic test_reset();
    idle_all();
    set0(1'b1, 1'b0, 8'h33, 4'hF, 32'h1234_5678);
    set1(1'b0, 1'b1, 8'h44, 4'hF, 32'h8765_4321);
    wb_rst_i = 1;
    @(negedge clk);
    n_cmp++; if ({r0.gnt, r1.gnt} !== 2'b00) begin n_bad++; $display("FAIL rst_gnt: got %b want 00", {r0.gnt, r1.gnt}); end
    n_cmp++; if ({mgmt_ena, mgmt_wen, mgmt_wen_mask} !== 12'h0) begin n_bad++; $display("FAIL rst_mgmt_en: got %h want 000", {mgmt_ena, mgmt_wen, mgmt_wen_mask}); end
    n_cmp++; if ({mgmt_addr, mgmt_wdata} !== 40'h0) begin n_bad++; $display("FAIL rst_mgmt_bus: got %h want 0", {mgmt_addr, mgmt_wdata}); end
    n_cmp++; if ({r0.rvalid, r1.rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b want 00", {r0.rvalid, r1.rvalid}); end
    cyc(); idle_all(); wb_rst_i = 0;
  endtask

  task automatic test_write_read();
    cyc(); set0(1'b1, 1'b0, 8'h10, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    n_cmp++; if (r0.gnt !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b want 1", r0.gnt); end
    n_cmp++; if (mgmt_ena !== 2'b01 || mgmt_wen !== 2'b01) begin n_bad++; $display("FAIL wr_en: got ena=%b wen=%b want 01/01", mgmt_ena, mgmt_wen); end
    n_cmp++; if (mgmt_wen_mask !== 8'h0F) begin n_bad++; $display("FAIL wr_mask: got %h want 0f", mgmt_wen_mask); end
    n_cmp++; if (mgmt_addr !== 8'h10 || mgmt_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_bus: got %h/%h want 10/deadbeef", mgmt_addr, mgmt_wdata); end
    cyc(); set0(1'b0, 1'b0, 8'h10, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (mgmt_ena !== 2'b01 || mgmt_wen !== 2'b00 || mgmt_wen_mask !== 8'h00) begin n_bad++; $display("FAIL rd_en: got ena=%b wen=%b mask=%h want 01/00/00", mgmt_ena, mgmt_wen, mgmt_wen_mask); end
    n_cmp++; if (r0.rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_early: got %b want 0", r0.rvalid); end
    cyc(); idle_all();
    @(negedge clk);
    n_cmp++; if (r0.rvalid !== 1'b1 || r0.rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got v=%b d=%h want 1/deadbeef", r0.rvalid, r0.rdata); end
    n_cmp++; if (r1.rvalid !== 1'b0 || r1.rdata !== 32'h0) begin n_bad++; $display("FAIL rd_other: got v=%b d=%h want 0/0", r1.rvalid, r1.rdata); end
    cyc();
    @(negedge clk);
    n_cmp++; if (r0.rvalid !== 1'b0 || r0.rdata !== 32'h0) begin n_bad++; $display("FAIL rd_pulse: got v=%b d=%h want 0/0", r0.rvalid, r0.rdata); end
  endtask

  task automatic test_contention();
    int exp_w, prev_w;
    reset_pulse();
    prev_w = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      set0(1'b0, 1'b0, 8'(i), 4'h0, 32'h0);
      set1(1'b0, 1'b1, 8'(i), 4'h0, 32'h0);
      @(negedge clk);
      exp_w = (i / 4) % 2;
      n_cmp++; if (r0.gnt !== (exp_w == 0) || r1.gnt !== (exp_w == 1)) begin n_bad++; $display("FAIL cont_gnt[%0d]: got %b%b want r%0d", i, r1.gnt, r0.gnt, exp_w); end
      if (i > 0) begin
        n_cmp++; if (r0.rvalid !== (prev_w == 0) || r1.rvalid !== (prev_w == 1)) begin n_bad++; $display("FAIL cont_rvalid[%0d]: got %b%b want r%0d", i, r1.rvalid, r0.rvalid, prev_w); end
      end
      prev_w = exp_w;
    end
    cyc(); idle_all();
    @(negedge clk);
    n_cmp++; if (r1.rvalid !== 1'b1 || r0.rvalid !== 1'b0) begin n_bad++; $display("FAIL cont_last: got %b%b want 10", r1.rvalid, r0.rvalid); end
  endtask

  task automatic test_solo_stream();
    for (int i = 0; i < 10; i++) begin
      cyc(); idle_all(); set1(1'b1, 1'b1, 8'(i), 4'hF, 32'hA500_0000 + i);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(); set1(1'b0, 1'b1, 8'(i), 4'h0, 32'h0);
      @(negedge clk);
      n_cmp++; if (r1.gnt !== 1'b1 || mgmt_ena !== 2'b10) begin n_bad++; $display("FAIL solo_gnt[%0d]: got gnt=%b ena=%b want 1/10", i, r1.gnt, mgmt_ena); end
      if (i > 0) begin
        n_cmp++; if (r1.rvalid !== 1'b1 || r1.rdata !== 32'hA500_0000 + i - 1) begin n_bad++; $display("FAIL solo_data[%0d]: got v=%b d=%h want 1/%h", i, r1.rvalid, r1.rdata, 32'hA500_0000 + i - 1); end
      end
    end
    cyc(); idle_all();
    @(negedge clk);
    n_cmp++; if (r1.rvalid !== 1'b1 || r1.rdata !== 32'hA500_0009) begin n_bad++; $display("FAIL solo_tail: got v=%b d=%h want 1/a5000009", r1.rvalid, r1.rdata); end
    cyc();
    @(negedge clk);
    n_cmp++; if (r1.rvalid !== 1'b0) begin n_bad++; $display("FAIL solo_end: got %b want 0", r1.rvalid); end
  endtask

  task automatic test_byte_mask();
    cyc(); set1(1'b1, 1'b1, 8'h20, 4'hF, 32'hFFFF_FFFF);
    cyc(); set1(1'b1, 1'b1, 8'h20, 4'b0101, 32'h0000_0000);
    @(negedge clk);
    n_cmp++; if (mgmt_wen_mask !== 8'h50 || mgmt_ena !== 2'b10 || mgmt_wen !== 2'b10) begin n_bad++; $display("FAIL mask_wr: got mask=%h ena=%b wen=%b want 50/10/10", mgmt_wen_mask, mgmt_ena, mgmt_wen); end
    cyc(); set1(1'b0, 1'b1, 8'h20, 4'h0, 32'h0);
    cyc(); idle_all();
    @(negedge clk);
    n_cmp++; if (r1.rvalid !== 1'b1 || r1.rdata !== 32'hFF00_FF00) begin n_bad++; $display("FAIL mask_rd: got v=%b d=%h want 1/ff00ff00", r1.rvalid, r1.rdata); end
  endtask

  task automatic test_out_of_range();
    cyc(); idle_all();
    s0.req = 1; s0.we = 0; s0.blk = 1'b1; s0.addr = 8'h05;
    @(negedge clk);
    n_cmp++; if (s0.gnt !== 1'b1 || oor_ena !== 1'b0 || oor_wen !== 1'b0) begin n_bad++; $display("FAIL oor_acc: got gnt=%b ena=%b wen=%b want 1/0/0", s0.gnt, oor_ena, oor_wen); end
    cyc(); s0.blk = 1'b0;
    @(negedge clk);
    n_cmp++; if (s0.rvalid !== 1'b1 || s0.rdata !== 32'h0) begin n_bad++; $display("FAIL oor_rd: got v=%b d=%h want 1/0", s0.rvalid, s0.rdata); end
    n_cmp++; if (oor_ena !== 1'b1) begin n_bad++; $display("FAIL oor_inrange_ena: got %b want 1", oor_ena); end
    cyc(); idle_all();
    @(negedge clk);
    n_cmp++; if (s0.rvalid !== 1'b1 || s0.rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL oor_inrange_rd: got v=%b d=%h want 1/cafef00d", s0.rvalid, s0.rdata); end
  endtask

  task automatic test_reset_mid_read();
    // Four r0 reads fill the burst count, so without a reset r1 would win next.
    for (int i = 0; i < 4; i++) begin
      cyc(); idle_all(); set0(1'b0, 1'b0, 8'h10, 4'h0, 32'h0);
    end
    cyc();
    set0(1'b1, 1'b0, 8'h77, 4'hF, 32'h5555_AAAA);
    set1(1'b0, 1'b1, 8'h66, 4'h0, 32'h0);
    wb_rst_i = 1;
    @(negedge clk);
    n_cmp++; if (r0.rvalid !== 1'b0 || r0.rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rvalid: got v=%b d=%h want 0/0", r0.rvalid, r0.rdata); end
    n_cmp++; if ({r0.gnt, r1.gnt} !== 2'b00 || mgmt_ena !== 2'b00 || mgmt_wen_mask !== 8'h00) begin n_bad++; $display("FAIL mid_outs: got gnt=%b%b ena=%b mask=%h want 00/00/00", r0.gnt, r1.gnt, mgmt_ena, mgmt_wen_mask); end
    n_cmp++; if (mgmt_addr !== 8'h0 || mgmt_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_bus: got %h/%h want 0/0", mgmt_addr, mgmt_wdata); end
    cyc(); wb_rst_i = 0;
    set0(1'b0, 1'b0, 8'h10, 4'h0, 32'h0);
    set1(1'b0, 1'b1, 8'h10, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (r0.gnt !== 1'b1 || r1.gnt !== 1'b0) begin n_bad++; $display("FAIL mid_regrant: got %b%b want r0", r1.gnt, r0.gnt); end
    n_cmp++; if (r0.rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_dropped: got %b want 0", r0.rvalid); end
    cyc(); idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_contention();
    test_solo_stream();
    test_byte_mask();
    test_out_of_range();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
